// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : uart_pkg                                                    |
// | Purpose : Shared types and constants for the UART transmit path.      |
// |           arb_state_t is the arbiter FSM state type; UART_DATA_W is   |
// |           the byte width carried per request; UART_FRAME_BITS is the  |
// |           on-line frame length (start + 8 data + stop).               |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LAUNCH = 2'd1,
    ARB_WAIT   = 2'd2
  } arb_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : uart_rr_pick                                                |
// | Purpose : Combinational round-robin picker. Returns the first set bit |
// |           of the request mask searching upward from ptr+1, wrapping  |
// |           modulo NUM_REQ, so the last winner has lowest priority.     |
// | Ports   : req   [NUM_REQ-1:0]        request mask                     |
// |           ptr   [$clog2(NUM_REQ)-1:0] index of the previous winner    |
// |           idx   [$clog2(NUM_REQ)-1:0] index of the winner             |
// |           valid                       at least one request present    |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // (base + step) mod NUM_REQ; works for non power-of-two requester counts.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int               step);
    int sum;
    sum = (int'(base) + step) % NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Walk from the farthest candidate (ptr itself) to the nearest (ptr+1);
  // the last hit overwrites earlier ones, leaving the highest-priority winner.
  always_comb begin
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[wrap_add(ptr, k)]) begin
        idx = wrap_add(ptr, k);
      end
    end
  end

  assign valid = |req;

endmodule : uart_rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : uart_tx_arbiter                                             |
// | Purpose : Shares one uart_tx among NUM_REQ byte sources with          |
// |           round-robin arbitration. The winning byte is latched and    |
// |           presented with tx_start, which is held until uart_tx raises |
// |           tx_busy; the arbiter then waits for tx_busy to fall before  |
// |           arbitrating again. A launch that never sees tx_busy within  |
// |           LAUNCH_TIMEOUT clocks is dropped with an err_timeout pulse. |
// | Options : UART_ARB_LOCK_EN - when defined, a requester holding        |
// |           req_lock keeps the transmitter for consecutive bytes while  |
// |           it keeps requesting. Undefined: req_lock is ignored.        |
// | Ports   : clk, reset (async, active-high)                             |
// |           req[N], req_data[8N], req_lock[N]  requester side           |
// |           ack[N]                 one-cycle "byte latched" pulse       |
// |           tx_start, tx_data[8], tx_busy      uart_tx side             |
// |           owner                  index of current/last grant          |
// |           active                 high in LAUNCH or WAIT               |
// |           err_timeout            one-cycle pulse on launch abort      |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int LAUNCH_TIMEOUT = 65535
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_lock,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]     owner,
  output logic                           active,
  output logic                           err_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // Counter only has to reach LAUNCH_TIMEOUT-1.
  localparam int CNT_W = (LAUNCH_TIMEOUT > 1) ? $clog2(LAUNCH_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAUNCH_TIMEOUT - 1);

  arb_state_t               state_q;
  logic [IDX_W-1:0]         ptr_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [NUM_REQ-1:0]       ack_q;
  logic                     tx_start_q;
  logic [UART_DATA_W-1:0]   tx_data_q;
  logic [IDX_W-1:0]         owner_q;
  logic                     active_q;
  logic                     err_q;

  logic [IDX_W-1:0]         rr_idx_d;
  logic                     rr_vld_d;
  logic                     use_lock_d;
  logic [IDX_W-1:0]         grant_idx_d;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (rr_idx_d),
    .valid (rr_vld_d)
  );

`ifdef UART_ARB_LOCK_EN
  // Set when the last completed byte came from a locked requester; the
  // next arbitration then favours that requester if it is still asking.
  logic lock_q;
  assign use_lock_d = lock_q & req[owner_q];
`else
  logic unused_req_lock;
  assign unused_req_lock = ^req_lock;
  assign use_lock_d      = 1'b0;
`endif

  assign grant_idx_d = use_lock_d ? owner_q : rr_idx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      cnt_q      <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      owner_q    <= '0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (rr_vld_d) begin
            tx_data_q  <= req_data[UART_DATA_W*grant_idx_d +: UART_DATA_W];
            ack_q      <= NUM_REQ'(1) << grant_idx_d;
            owner_q    <= grant_idx_d;
            ptr_q      <= grant_idx_d;
            tx_start_q <= 1'b1;
            active_q   <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ARB_LAUNCH;
`ifdef UART_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
          end
        end

        ARB_LAUNCH: begin
          // tx_busy wins over the timeout when both happen together.
          if (tx_busy) begin
            tx_start_q <= 1'b0;
            state_q    <= ARB_WAIT;
          end else if (cnt_q == CNT_LAST) begin
            // Byte was already acked to its source, so it is simply lost.
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
            err_q      <= 1'b1;
            state_q    <= ARB_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ARB_WAIT: begin
          if (!tx_busy) begin
            active_q <= 1'b0;
            state_q  <= ARB_IDLE;
`ifdef UART_ARB_LOCK_EN
            lock_q   <= req_lock[owner_q];
`endif
          end
        end

        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign owner       = owner_q;
  assign active      = active_q;
  assign err_timeout = err_q;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_uart_tx_arbiter                                          |
// | Purpose : Self-checking bench for uart_tx_arbiter. A transaction-level|
// |           reference (rotating priority list, launch age, expected    |
// |           byte queue) predicts every output each cycle; a simple      |
// |           uart_tx stand-in serialises accepted bytes into 10-bit      |
// |           frames. A second instance with LAUNCH_TIMEOUT=8 and a       |
// |           hand-driven tx_busy exercises the abort path.               |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int LT = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   req, req_lock, ack;
  logic [8*N-1:0] req_data;
  logic           tx_start, tx_busy, active, err_timeout;
  logic [7:0]     tx_data;
  logic [1:0]     owner;

  logic [N-1:0]   req_to, lock_to, ack_to;
  logic [8*N-1:0] data_to;
  logic           start_to, busy_to, active_to, err_to;
  logic [7:0]     txd_to;
  logic [1:0]     owner_to;

  uart_tx_arbiter #(.NUM_REQ(N)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .req_lock(req_lock), .ack(ack), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .owner(owner), .active(active), .err_timeout(err_timeout)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .LAUNCH_TIMEOUT(8)) u_dut_to (
    .clk(clk), .reset(reset), .req(req_to), .req_data(data_to),
    .req_lock(lock_to), .ack(ack_to), .tx_start(start_to), .tx_data(txd_to),
    .tx_busy(busy_to), .owner(owner_to), .active(active_to), .err_timeout(err_to)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: evaluated at every rising edge from the inputs.
  // ------------------------------------------------------------------
  logic [N-1:0] m_ack;
  logic         m_start, m_active, m_err;
  logic [7:0]   m_data;
  int           m_owner, m_last, m_age;
  bit           m_launching, m_waiting;
  logic [7:0]   exp_q[$];

  // Priority order is last+1, last+2, ... wrapping; first requester set wins.
  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    int order[$];
    for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic model_reset();
    m_ack = '0; m_start = 0; m_active = 0; m_err = 0; m_data = '0;
    m_owner = 0; m_last = N - 1; m_age = 0;
    m_launching = 0; m_waiting = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int w;
    m_ack = '0;
    m_err = 0;
    if (m_launching) begin
      if (tx_busy) begin
        m_start = 0; m_launching = 0; m_waiting = 1;
      end else if (m_age == LT - 1) begin
        m_start = 0; m_active = 0; m_err = 1; m_launching = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
      end else begin
        m_age++;
      end
    end else if (m_waiting) begin
      if (!tx_busy) begin
        m_active = 0; m_waiting = 0;
      end
    end else begin
      w = rr_winner(req, m_last);
      if (w >= 0) begin
        m_ack[w]    = 1'b1;
        m_data      = req_data[8*w +: 8];
        m_owner     = w;
        m_last      = w;
        m_start     = 1;
        m_active    = 1;
        m_age       = 0;
        m_launching = 1;
        exp_q.push_back(m_data);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ------------------------------------------------------------------
  // Per-cycle comparison of every registered output.
  // ------------------------------------------------------------------
  bit cmp_en = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cycle_outputs",
              {15'd0, ack, tx_start, tx_data, owner, active, err_timeout},
              {15'd0, m_ack, m_start, m_data, 2'(m_owner), m_active, m_err});
      end
    end
  end

  // ------------------------------------------------------------------
  // uart_tx stand-in: samples tx_start on baud ticks while idle, then
  // shifts a 10-bit frame (start, 8 data LSB first, stop) one bit per tick.
  // ------------------------------------------------------------------
  int         baud_div = 16;
  int         div_cnt;
  int         u_bits;
  bit         u_busy, tick;
  logic [9:0] u_sh, u_frame;
  logic [9:0] frame_log[$];

  initial begin
    tx_busy = 1'b0; u_busy = 0; div_cnt = 0; u_bits = 0; u_sh = '0; u_frame = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        u_busy = 0; div_cnt = 0; u_bits = 0;
      end else begin
        tick = (div_cnt >= baud_div - 1);
        div_cnt = tick ? 0 : div_cnt + 1;
        if (tick) begin
          if (!u_busy) begin
            if (tx_start) begin
              u_sh = {1'b1, tx_data, 1'b0}; u_bits = 0; u_busy = 1;
            end
          end else begin
            u_frame[u_bits] = u_sh[0];
            u_sh = u_sh >> 1;
            u_bits++;
            if (u_bits == UART_FRAME_BITS) begin
              u_busy = 0;
              frame_log.push_back(u_frame);
              check("frame_was_expected", exp_q.size() != 0, 1);
              if (exp_q.size() != 0) check("frame_bits", u_frame, {1'b1, exp_q.pop_front(), 1'b0});
            end
          end
        end
      end
      tx_busy = u_busy;
    end
  end

  // ------------------------------------------------------------------
  // Requester agent: on ack, either withdraw or present the next byte.
  // ------------------------------------------------------------------
  int left[N];
  bit rand_en = 0;
  int grant_log[$];

  task automatic agent();
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        grant_log.push_back(i);
        if (left[i] > 0) left[i]--;
        if (left[i] == 0) req[i] = 1'b0;
        else if (rand_en) req_data[8*i +: 8] = 8'($urandom);
      end
    end
    if (rand_en) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 15) == 0) begin
          left[i] = $urandom_range(1, 3);
          req_data[8*i +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    agent();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(req == '0 && !active && !tx_busy) && n < budget) begin
      step();
      n++;
    end
    check(name, (req == '0 && !active && !tx_busy), 1);
  endtask

  task automatic wait_in_wait(input string name, input int budget);
    int n;
    n = 0;
    while (!(tx_busy && active && !tx_start) && n < budget) begin
      step();
      n++;
    end
    check(name, (tx_busy && active && !tx_start), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, errs, err_at, f0;
    reset = 1'b1; req = '0; req_data = '0; req_lock = '0;
    req_to = '0; data_to = '0; lock_to = '0; busy_to = 1'b0;
    for (int i = 0; i < N; i++) left[i] = 0;
    repeat (3) @(negedge clk);

    check("rst_ack", ack, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_owner", owner, 0);
    check("rst_active", active, 0);
    check("rst_err", err_timeout, 0);
    reset = 1'b0;
    cmp_en = 1;
    step();

    // Single byte 0x55 from requester 0, one-clock ack latency.
    req[0] = 1'b1; req_data[7:0] = 8'h55; left[0] = 1;
    step();
    check("lat_ack0", ack, 4'b0001);
    check("lat_tx_start", tx_start, 1);
    check("lat_tx_data", tx_data, 8'h55);
    wait_in_wait("reach_wait_0", 400);

    // Requester 2 arrives while requester 0's frame is in flight.
    req[2] = 1'b1; req_data[23:16] = 8'h3C; left[2] = 1;
    wait_idle("idle_after_A", 1000);
    check("grants_A", grant_log.size(), 2);
    if (grant_log.size() == 2) check("served_next_2", grant_log[1], 2);
    check("frames_A", frame_log.size(), 2);
    if (frame_log.size() == 2) begin
      check("frame_0x55", frame_log[0], 10'h2AA);
      check("frame_0x3C", frame_log[1], 10'h278);
    end

    // Asynchronous reset in the middle of a WAIT.
    req[3] = 1'b1; req_data[31:24] = 8'h81; left[3] = 1;
    wait_in_wait("reach_wait_3", 400);
    repeat (5) step();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_tx_start", tx_start, 0);
    check("async_active", active, 0);
    check("async_owner", owner, 0);
    step();
    step();
    reset = 1'b0;
    grant_log.delete();
    req[1] = 1'b1; req_data[15:8]  = 8'h11; left[1] = 1;
    req[3] = 1'b1; req_data[31:24] = 8'h33; left[3] = 1;
    step();
    check("post_rst_ack1", ack, 4'b0010);
    check("post_rst_owner1", owner, 1);
    wait_idle("idle_after_rst", 1000);
    check("grants_rst", grant_log.size(), 2);
    if (grant_log.size() == 2) check("then_3", grant_log[1], 3);

    // All four requesters held: strict rotation, each once per 4 grants.
    grant_log.delete();
    f0 = frame_log.size();
    for (int i = 0; i < N; i++) begin
      req_data[8*i +: 8] = 8'hA0 + 8'(i);
      left[i] = 3;
    end
    req = 4'b1111;
    wait_idle("idle_after_B", 5000);
    check("grants_B", grant_log.size(), 12);
    for (int k = 0; k < 12; k++) begin
      if (k < grant_log.size()) check("rr_order", grant_log[k], k % N);
    end
    check("frames_B", frame_log.size() - f0, 12);

    // Randomised traffic at a faster baud.
    baud_div = 4;
    rand_en = 1;
    repeat (3000) step();
    rand_en = 0;
    wait_idle("idle_after_rand", 3000);
    check("exp_q_drained", exp_q.size(), 0);

    // Launch timeout on the short-timeout instance, tx_busy held low.
    req_to = 4'b0001; data_to[7:0] = 8'h77;
    hi = 0; errs = 0; err_at = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("to_ack", ack_to, 4'b0001);
        req_to = '0;
      end
      if (start_to) hi++;
      if (err_to) begin errs++; err_at = c; end
    end
    check("to_start_cycles", hi, 8);
    check("to_err_count", errs, 1);
    check("to_err_cycle", err_at, 9);
    check("to_active_idle", active_to, 0);

    // tx_busy arriving on the final launch cycle beats the timeout.
    req_to = 4'b0100; data_to[23:16] = 8'h99;
    errs = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (err_to) errs++;
      if (c == 1) begin
        check("to2_ack", ack_to, 4'b0100);
        check("to2_owner", owner_to, 2);
        req_to = '0;
      end
      if (c == 8) busy_to = 1'b1;
      if (c == 9) begin
        check("to2_start_dropped", start_to, 0);
        check("to2_active_wait", active_to, 1);
        busy_to = 1'b0;
      end
      if (c == 10) check("to2_active_done", active_to, 0);
    end
    check("to2_no_err", errs, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter among NUM_REQ byte requesters using round-robin arbitration.
- Latches the winning byte, drives tx_start/tx_data, holds tx_start until uart_tx raises tx_busy, then waits for tx_busy to fall before re-arbitrating.
- Sits between the requesting blocks (command/status/debug sources) and uart_tx; baud timing stays entirely inside uart_tx.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LAUNCH_TIMEOUT, 65535, clk cycles allowed in LAUNCH for tx_busy to rise before the byte is aborted.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- req  input  NUM_REQ  per-requester level request; held until its ack.
- req_data  input  8*NUM_REQ  byte of requester i at [8*i+7:8*i].
- req_lock  input  NUM_REQ  per-requester packet lock (used only with UART_ARB_LOCK_EN).
- ack  output  NUM_REQ  one-cycle pulse: byte of requester i latched.
- tx_start  output  1  to uart_tx.
- tx_data  output  8  to uart_tx.
- tx_busy  input  1  from uart_tx.
- owner  output  $clog2(NUM_REQ)  index of current/last grant.
- active  output  1  high in LAUNCH or WAIT.
- err_timeout  output  1  one-cycle pulse on launch abort.

Behaviour:
- Clock clk; reset is asynchronous, active-high. Reset values: tx_start=0, tx_data=0, ack=0, owner=0, active=0, err_timeout=0, state=ARB_IDLE, rr pointer=NUM_REQ-1 (req[0] has first priority), timeout counter=0. All outputs are registered.
- ARB_IDLE:
  - If req!=0, the winner is the first set bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - Next edge: tx_data<=winner byte, ack[winner]<=1 (one cycle), owner<=winner, pointer<=winner, tx_start<=1, active<=1, counter<=0, go to ARB_LAUNCH.
  - If req==0, stay in ARB_IDLE.
- ARB_LAUNCH:
  - tx_start stays 1; uart_tx samples it only on a baud tick in its IDLE state.
  - tx_busy==1: tx_start<=0, go to ARB_WAIT.
  - Else if counter==LAUNCH_TIMEOUT-1: tx_start<=0, active<=0, err_timeout<=1 (one cycle), byte discarded (already acked), go to ARB_IDLE.
  - Else counter increments.
  - tx_busy takes priority over timeout on the same cycle.
- ARB_WAIT: tx_busy==0 -> active<=0, go to ARB_IDLE. New arbitration is possible on the following cycle, giving minimum 1 idle clk between launches.
- Latency: req seen in ARB_IDLE -> ack and tx_start asserted 1 clk later.
- Requests arriving during LAUNCH/WAIT are held by the requester and are not lost. ack never fires for a requester whose req is low.
- Simultaneous requests are resolved purely by the rr pointer. With all requesters active, each gets exactly 1 byte per NUM_REQ grants.
- Reset mid-operation drops the in-flight byte. tx_start goes low immediately (async).
- Requester contract: req_data is stable while req is high.

Optional Feature:
- Macro UART_ARB_LOCK_EN.
- Defined: on the ARB_WAIT->ARB_IDLE transition, if req_lock[owner]==1, the next arbitration grants owner whenever req[owner]==1, ignoring the pointer. This sends multi-byte packets unbroken. If req[owner]==0, normal round-robin applies. The pointer still updates to owner.
- Not defined: req_lock is ignored (port kept for a stable interface), pure round-robin.

Decomposition:
- Package uart_pkg holds:
  - enum arb_state_t {ARB_IDLE, ARB_LAUNCH, ARB_WAIT};
  - constant UART_DATA_W=8;
  - constant UART_FRAME_BITS=10.
- One sub-module: uart_rr_pick. Combinational; inputs req mask, pointer; outputs winner index and valid.

Test Plan:
- req=4'b0001, byte 0x55, uart_tx with baud_tick every 16 clk -> ack[0] pulses 1 clk after req; tx_start held until tx_busy=1; 10-bit frame 0x55 observed on tx; active falls after tx_busy falls.
- req=4'b1111 held, bytes 0xA0..0xA3 -> grant order 0,1,2,3,0,…; each ack exactly once per 4 frames.
- req[2] arrives during WAIT of requester 0 -> served next; no dropped ack.
- tx_busy tied 0, LAUNCH_TIMEOUT=8 -> tx_start high 8 clk, then err_timeout pulses once, state returns to ARB_IDLE.
- Reset asserted mid-WAIT -> tx_start=0, active=0, owner=0 asynchronously; after release, req[1] and req[3] both high -> req[1] wins.
- UART_ARB_LOCK_EN defined, req_lock[1]=1, req=4'b0011 -> three consecutive bytes from requester 1, then requester 0 after req_lock[1] drops.
